// File: rtl/up3_control.sv
// Fetch/decode/execute sequencer for the up3 datapath: two-byte instructions, 6 cycles each.
// Outputs are decoded from the state register; the only input-dependent output is load_pc in EX_JNEG.
module up3_control (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] opcode,
  input  logic       ac_neg,
  output logic       store_mem,
  output logic       fetch,
  output logic       load_pc,
  output logic       incr_pc,
  output logic       load_iru,
  output logic       load_irl,
  output logic       load_ac,
  output logic [1:0] alu_op,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       halted
);

  localparam logic [7:0] OP_ADD   = 8'h00;
  localparam logic [7:0] OP_STORE = 8'h01;
  localparam logic [7:0] OP_LOAD  = 8'h02;
  localparam logic [7:0] OP_JUMP  = 8'h03;
  localparam logic [7:0] OP_JNEG  = 8'h04;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FH_A     = 4'd1,
    S_FH_L     = 4'd2,
    S_FL_A     = 4'd3,
    S_FL_L     = 4'd4,
    S_DECODE   = 4'd5,
    S_EX_ADD   = 4'd6,
    S_EX_LOAD  = 4'd7,
    S_EX_STORE = 4'd8,
    S_EX_JUMP  = 4'd9,
    S_EX_JNEG  = 4'd10,
    S_EX_NOP   = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  state_t r_state;
  state_t w_next;
  state_t w_after_ex;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // run is only consulted at instruction boundaries, so a drop mid-instruction lets it finish
  assign w_after_ex = run ? S_FH_A : S_IDLE;

  always_comb begin
    w_next     = r_state;
    store_mem  = 1'b0;
    fetch      = 1'b0;
    load_pc    = 1'b0;
    incr_pc    = 1'b0;
    load_iru   = 1'b0;
    load_irl   = 1'b0;
    load_ac    = 1'b0;
    alu_op     = 2'b00;
    instr_done = 1'b0;
    halted     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_next = S_FH_A;
      end
      S_FH_A: begin
        fetch  = 1'b1;
        w_next = S_FH_L;
      end
      S_FH_L: begin
        fetch    = 1'b1;
        load_iru = 1'b1;
        incr_pc  = 1'b1;
        w_next   = S_FL_A;
      end
      S_FL_A: begin
        fetch  = 1'b1;
        w_next = S_FL_L;
      end
      S_FL_L: begin
        fetch    = 1'b1;
        load_irl = 1'b1;
        incr_pc  = 1'b1;
        w_next   = S_DECODE;
      end
      S_DECODE: begin
        // fetch stays low here so the operand address reaches memory one cycle ahead of execute
        case (opcode)
          OP_ADD:   w_next = S_EX_ADD;
          OP_STORE: w_next = S_EX_STORE;
          OP_LOAD:  w_next = S_EX_LOAD;
          OP_JUMP:  w_next = S_EX_JUMP;
          OP_JNEG:  w_next = S_EX_JNEG;
          OP_HALT:  w_next = S_HALT;
          default:  w_next = S_EX_NOP;
        endcase
      end
      S_EX_ADD: begin
        load_ac    = 1'b1;
        alu_op     = 2'b01;
        instr_done = 1'b1;
        w_next     = w_after_ex;
      end
      S_EX_LOAD: begin
        load_ac    = 1'b1;
        alu_op     = 2'b00;
        instr_done = 1'b1;
        w_next     = w_after_ex;
      end
      S_EX_STORE: begin
        store_mem  = 1'b1;
        instr_done = 1'b1;
        w_next     = w_after_ex;
      end
      S_EX_JUMP: begin
        load_pc    = 1'b1;
        instr_done = 1'b1;
        w_next     = w_after_ex;
      end
      S_EX_JNEG: begin
        load_pc    = ac_neg;
        instr_done = 1'b1;
        w_next     = w_after_ex;
      end
      S_EX_NOP: begin
        instr_done = 1'b1;
        w_next     = w_after_ex;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign state = r_state;

endmodule
